// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared definitions for the MMC3-style scanline IRQ unit: register select codes
// (decoded from CPU A14,A13,A0) and default A12 filter sizing.
package mmc3_scanline_irq_pkg;

    localparam int FILTER_CYCLES_DEF = 3;
    localparam int LOW_CNT_W_DEF     = 2;

    typedef enum logic [2:0] {
        IRQ_LATCH   = 3'b100,
        IRQ_RELOAD  = 3'b101,
        IRQ_DISABLE = 3'b110,
        IRQ_ENABLE  = 3'b111
    } irq_reg_e;

    function automatic logic [2:0] reg_sel(input logic [14:0] addr);
        return {addr[14], addr[13], addr[0]};
    endfunction

endpackage

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// PPU A12 synchroniser and low-time filter. The clock pulse is combinational and
// qualifies the m2 falling edge at which the synchronised A12 goes 0->1.
module a12_edge_filter #(
    parameter int FILTER_CYCLES = 3,
    parameter int LOW_CNT_W     = 2
) (
    input  logic m2,
    input  logic reset,
    input  logic ppu_a12,
    output logic o_scanline_clk
);

    localparam logic [LOW_CNT_W-1:0] FILTER_MIN = LOW_CNT_W'(FILTER_CYCLES);

    logic [1:0]           r_sync;
    logic [LOW_CNT_W-1:0] r_low_cnt;

    // r_sync[0] is the value r_sync[1] takes at this edge, so the low counter
    // tracks how many consecutive edges the synchronised A12 has been low.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            r_sync    <= 2'b00;
            r_low_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], ppu_a12};
            if (r_sync[0])
                r_low_cnt <= '0;
            else if (r_low_cnt != {LOW_CNT_W{1'b1}})
                r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

    assign o_scanline_clk = r_sync[0] & ~r_sync[1] & (r_low_cnt >= FILTER_MIN);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ: $C000-$FFFF register decode, reload/decrement counter,
// sticky pending flag, open-drain /IRQ. Define MMC3_IRQ_OLD_STYLE_EN for MMC3A/NEC firing rules.
module mmc3_scanline_irq
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int LOW_CNT_W     = LOW_CNT_W_DEF
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        enable,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    output wire         irq,
    output logic        irq_pending
);

    logic [7:0] r_latch;
    logic [7:0] r_counter;
    logic       r_reload_flag;
    logic       r_irq_en;
    logic       r_pending;

    logic       w_scanline_clk;
    logic       w_write;
    logic [2:0] w_sel;
    logic       w_wr_latch, w_wr_reload, w_wr_disable, w_wr_enable;
    logic [7:0] w_counter_pre, w_counter_next, w_latch_next;
    logic       w_reload_eff, w_reload_next, w_irq_en_next, w_fire, w_pending_next;

    a12_edge_filter #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .LOW_CNT_W    (LOW_CNT_W)
    ) u_filter (
        .m2            (m2),
        .reset         (reset),
        .ppu_a12       (ppu_a12),
        .o_scanline_clk(w_scanline_clk)
    );

    assign w_write      = enable & ~romsel & ~cpu_rw_in;
    assign w_sel        = reg_sel(cpu_addr_in);
    assign w_wr_latch   = w_write & (w_sel == IRQ_LATCH);
    assign w_wr_reload  = w_write & (w_sel == IRQ_RELOAD);
    assign w_wr_disable = w_write & (w_sel == IRQ_DISABLE);
    assign w_wr_enable  = w_write & (w_sel == IRQ_ENABLE);

    // Register writes land first; the scanline clock then acts on the written
    // counter/flag/enable, but reloads from the pre-edge latch.
    always_comb begin
        w_latch_next   = w_wr_latch ? cpu_data_in : r_latch;
        w_irq_en_next  = w_wr_enable ? 1'b1 : (w_wr_disable ? 1'b0 : r_irq_en);
        w_counter_pre  = w_wr_reload ? 8'd0 : r_counter;
        w_reload_eff   = r_reload_flag | w_wr_reload;
        w_counter_next = w_counter_pre;
        w_reload_next  = w_reload_eff;
        w_fire         = 1'b0;
        if (w_scanline_clk) begin
            w_reload_next = 1'b0;
            if ((w_counter_pre == 8'd0) || w_reload_eff)
                w_counter_next = r_latch;
            else
                w_counter_next = w_counter_pre - 8'd1;
`ifdef MMC3_IRQ_OLD_STYLE_EN
            w_fire = (w_counter_next == 8'd0) && w_irq_en_next &&
                     ((w_counter_pre != 8'd0) || w_reload_eff);
`else
            w_fire = (w_counter_next == 8'd0) && w_irq_en_next;
`endif
        end
        w_pending_next = w_wr_disable ? 1'b0 : (w_fire ? 1'b1 : r_pending);
    end

    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            r_latch       <= 8'd0;
            r_counter     <= 8'd0;
            r_reload_flag <= 1'b0;
            r_irq_en      <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_latch       <= w_latch_next;
            r_counter     <= w_counter_next;
            r_reload_flag <= w_reload_next;
            r_irq_en      <= w_irq_en_next;
            r_pending     <= w_pending_next;
        end
    end

    assign irq_pending = r_pending;
    assign irq         = (enable & r_pending) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq; /IRQ is observed through a pulled-up net.
module tb_mmc3_scanline_irq;

    logic        m2 = 1'b1;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        romsel = 1'b1;
    logic        cpu_rw_in = 1'b1;
    logic [14:0] cpu_addr_in = 15'h0;
    logic [7:0]  cpu_data_in = 8'h0;
    logic        ppu_a12 = 1'b1;
    wire         irq_line;
    logic        irq_pending;

    int n_cmp = 0;
    int n_fail = 0;

    pullup (irq_line);

    mmc3_scanline_irq dut (
        .m2         (m2),
        .reset      (reset),
        .enable     (enable),
        .romsel     (romsel),
        .cpu_rw_in  (cpu_rw_in),
        .cpu_addr_in(cpu_addr_in),
        .cpu_data_in(cpu_data_in),
        .ppu_a12    (ppu_a12),
        .irq        (irq_line),
        .irq_pending(irq_pending)
    );

    always #10 m2 = ~m2;

    // inputs change and outputs are sampled 1 ns after each falling edge
    task automatic tick();
        @(negedge m2);
        #1;
    endtask

    task automatic drive_wr(input logic [14:0] addr, input logic [7:0] data);
        romsel      = 1'b0;
        cpu_rw_in   = 1'b0;
        cpu_addr_in = addr;
        cpu_data_in = data;
    endtask

    task automatic drive_idle();
        romsel    = 1'b1;
        cpu_rw_in = 1'b1;
    endtask

    task automatic cpu_write(input logic [14:0] addr, input logic [7:0] data);
        drive_wr(addr, data);
        tick();
        drive_idle();
    endtask

    // low for 3 m2 cycles, then rise; the clock lands on the 2nd edge after the rise
    task automatic scanline_wr(input bit do_wr, input logic [14:0] addr, input logic [7:0] data);
        ppu_a12 = 1'b0;
        repeat (3) tick();
        ppu_a12 = 1'b1;
        tick();
        if (do_wr) drive_wr(addr, data);
        tick();
        drive_idle();
    endtask

    task automatic scanline();
        scanline_wr(1'b0, 15'h0, 8'h0);
    endtask

    task automatic glitch(input int n_low);
        ppu_a12 = 1'b0;
        repeat (n_low) tick();
        ppu_a12 = 1'b1;
        repeat (3) tick();
    endtask

    task automatic setup_count(input logic [7:0] latch);
        cpu_write(15'h6000, 8'h00);
        cpu_write(15'h4000, latch);
        cpu_write(15'h4001, 8'h00);
        scanline();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++; if (irq_line !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b want 1", irq_line); end
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", irq_pending); end
        n_cmp++; if (dut.r_counter !== 8'd0) begin n_fail++; $display("FAIL reset_counter: got %0d want 0", dut.r_counter); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_count();
        cpu_write(15'h4000, 8'd5);
        cpu_write(15'h4001, 8'h00);
        cpu_write(15'h6001, 8'h00);
        repeat (5) scanline();
        n_cmp++; if (dut.r_counter !== 8'd1) begin n_fail++; $display("FAIL basic_cnt5: got %0d want 1", dut.r_counter); end
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", irq_pending); end
        scanline();
        n_cmp++; if (dut.r_counter !== 8'd0) begin n_fail++; $display("FAIL basic_cnt6: got %0d want 0", dut.r_counter); end
        n_cmp++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending: got %b want 1", irq_pending); end
        n_cmp++; if (irq_line !== 1'b0) begin n_fail++; $display("FAIL basic_irq_low: got %b want 0", irq_line); end
        cpu_write(15'h6000, 8'h00);
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got %b want 0", irq_pending); end
        n_cmp++; if (irq_line !== 1'b1) begin n_fail++; $display("FAIL basic_release: got %b want 1", irq_line); end
    endtask

    task automatic test_async_reset();
        cpu_write(15'h4000, 8'd1);
        cpu_write(15'h4001, 8'h00);
        cpu_write(15'h6001, 8'h00);
        scanline();
        scanline();
        n_cmp++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b want 1", irq_pending); end
        #4;
        reset = 1'b1;
        #1;
        n_cmp++; if (irq_line !== 1'b1) begin n_fail++; $display("FAIL areset_irq: got %b want 1", irq_line); end
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL areset_pending: got %b want 0", irq_pending); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (dut.r_counter !== 8'd0) begin n_fail++; $display("FAIL areset_counter: got %0d want 0", dut.r_counter); end
        n_cmp++; if (dut.r_irq_en !== 1'b0) begin n_fail++; $display("FAIL areset_irq_en: got %b want 0", dut.r_irq_en); end
    endtask

    task automatic test_a12_filter();
        setup_count(8'd10);
        n_cmp++; if (dut.r_counter !== 8'd10) begin n_fail++; $display("FAIL filt_setup: got %0d want 10", dut.r_counter); end
        glitch(1);
        n_cmp++; if (dut.r_counter !== 8'd10) begin n_fail++; $display("FAIL filt_low1: got %0d want 10", dut.r_counter); end
        glitch(2);
        n_cmp++; if (dut.r_counter !== 8'd10) begin n_fail++; $display("FAIL filt_low2: got %0d want 10", dut.r_counter); end
        glitch(3);
        n_cmp++; if (dut.r_counter !== 8'd9) begin n_fail++; $display("FAIL filt_low3: got %0d want 9", dut.r_counter); end
    endtask

    task automatic test_simultaneous_writes();
        setup_count(8'd9);
        cpu_write(15'h4000, 8'd8);
        scanline_wr(1'b1, 15'h4001, 8'h00);
        n_cmp++; if (dut.r_counter !== 8'd8) begin n_fail++; $display("FAIL sim_reload_cnt: got %0d want 8", dut.r_counter); end
        n_cmp++; if (dut.r_reload_flag !== 1'b0) begin n_fail++; $display("FAIL sim_reload_flag: got %b want 0", dut.r_reload_flag); end
        scanline();
        n_cmp++; if (dut.r_counter !== 8'd7) begin n_fail++; $display("FAIL sim_next_dec: got %0d want 7", dut.r_counter); end
        cpu_write(15'h4001, 8'h00);
        scanline_wr(1'b1, 15'h4000, 8'd3);
        n_cmp++; if (dut.r_counter !== 8'd8) begin n_fail++; $display("FAIL sim_old_latch: got %0d want 8", dut.r_counter); end
        n_cmp++; if (dut.r_latch !== 8'd3) begin n_fail++; $display("FAIL sim_new_latch: got %0d want 3", dut.r_latch); end
    endtask

    task automatic test_latch_zero();
        logic exp_natural;
`ifdef MMC3_IRQ_OLD_STYLE_EN
        exp_natural = 1'b0;
`else
        exp_natural = 1'b1;
`endif
        cpu_write(15'h6000, 8'h00);
        cpu_write(15'h4000, 8'd0);
        cpu_write(15'h4001, 8'h00);
        cpu_write(15'h6001, 8'h00);
        scanline();
        n_cmp++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL zero_forced: got %b want 1", irq_pending); end
        cpu_write(15'h6000, 8'h00);
        cpu_write(15'h6001, 8'h00);
        scanline();
        n_cmp++; if (irq_pending !== exp_natural) begin n_fail++; $display("FAIL zero_natural1: got %b want %b", irq_pending, exp_natural); end
        cpu_write(15'h6000, 8'h00);
        cpu_write(15'h6001, 8'h00);
        scanline();
        n_cmp++; if (irq_pending !== exp_natural) begin n_fail++; $display("FAIL zero_natural2: got %b want %b", irq_pending, exp_natural); end
        cpu_write(15'h6000, 8'h00);
        cpu_write(15'h6001, 8'h00);
        cpu_write(15'h4001, 8'h00);
        scanline_wr(1'b1, 15'h6000, 8'h00);
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL zero_clear_wins: got %b want 0", irq_pending); end
        cpu_write(15'h4001, 8'h00);
        scanline_wr(1'b1, 15'h6001, 8'h00);
        n_cmp++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL zero_enable_same_edge: got %b want 1", irq_pending); end
        cpu_write(15'h6000, 8'h00);
    endtask

    task automatic test_enable_off();
        setup_count(8'd2);
        enable = 1'b0;
        cpu_write(15'h6001, 8'h00);
        cpu_write(15'h4000, 8'd7);
        cpu_write(15'h4001, 8'h00);
        scanline();
        scanline();
        n_cmp++; if (dut.r_counter !== 8'd0) begin n_fail++; $display("FAIL en_off_count: got %0d want 0", dut.r_counter); end
        n_cmp++; if (dut.r_irq_en !== 1'b0) begin n_fail++; $display("FAIL en_off_irq_en: got %b want 0", dut.r_irq_en); end
        n_cmp++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL en_off_pending: got %b want 0", irq_pending); end
        n_cmp++; if (irq_line !== 1'b1) begin n_fail++; $display("FAIL en_off_irq: got %b want 1", irq_line); end
        n_cmp++; if (dut.r_latch !== 8'd2) begin n_fail++; $display("FAIL en_off_latch: got %0d want 2", dut.r_latch); end
        enable = 1'b1;
        cpu_write(15'h0000, 8'hff);
        cpu_write(15'h0001, 8'hff);
        cpu_write(15'h2000, 8'hff);
        cpu_write(15'h2001, 8'hff);
        n_cmp++; if (dut.r_latch !== 8'd2) begin n_fail++; $display("FAIL low_bank_latch: got %0d want 2", dut.r_latch); end
        n_cmp++; if (dut.r_irq_en !== 1'b0) begin n_fail++; $display("FAIL low_bank_irq_en: got %b want 0", dut.r_irq_en); end
        n_cmp++; if (dut.r_reload_flag !== 1'b0) begin n_fail++; $display("FAIL low_bank_reload: got %b want 0", dut.r_reload_flag); end
        cpu_write(15'h4000, 8'd0);
        cpu_write(15'h4001, 8'h00);
        cpu_write(15'h6001, 8'h00);
        scanline();
        enable = 1'b0;
        #1;
        n_cmp++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL en_off_visible: got %b want 1", irq_pending); end
        n_cmp++; if (irq_line !== 1'b1) begin n_fail++; $display("FAIL en_off_forced_z: got %b want 1", irq_line); end
        enable = 1'b1;
        #1;
        n_cmp++; if (irq_line !== 1'b0) begin n_fail++; $display("FAIL en_on_drive: got %b want 0", irq_line); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_async_reset();
        test_a12_filter();
        test_simultaneous_writes();
        test_latch_zero();
        test_enable_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
